// File: rtl/lpc_pkg.sv
// lpc_pkg: shared constants and types for the LPC decoder-side synthesis filter.
//   N_SAMPLES : samples per frame (x/residue address range 0..N_SAMPLES-1)
//   ORDER     : predictor order (number of a[k] coefficients)
//   COEF_FRAC : fractional bits of the signed Q8.24 coefficients
//   ACC_W     : signed multiply-accumulate width
package lpc_pkg;

  localparam int N_SAMPLES = 160;
  localparam int ORDER     = 10;
  localparam int COEF_FRAC = 24;
  localparam int ACC_W     = 48;

  localparam int SAMP_W = 16;
  localparam int COEF_W = 32;

  // Width of the rounded prediction and of the un-saturated output e - p.
  localparam int P_W = ACC_W - COEF_FRAC;
  localparam int Y_W = P_W + 1;

  typedef logic signed [SAMP_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_WRITE
  } synth_state_e;

endpackage

// File: rtl/lpc_synth_mac.sv
// lpc_synth_mac: accumulator and output datapath of the synthesis filter.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   clr          : zero the accumulator at the next edge (sample load)
//   mac_en       : add a_r * hist_k to the accumulator at the next edge
//   a_r          : selected coefficient, signed Q8.24
//   hist_k       : history sample paired with a_r
//   e            : current residue sample
//   y_sat        : saturated reconstructed sample e - round(acc)
//   y_ovf        : high when y_sat had to be clipped
module lpc_synth_mac
  import lpc_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    clr,
  input  logic    mac_en,
  input  coef_t   a_r,
  input  sample_t hist_k,
  input  sample_t e,
  output sample_t y_sat,
  output logic    y_ovf
);

  localparam logic signed [ACC_W-1:0] RND   = ACC_W'(1) <<< (COEF_FRAC - 1);
  localparam logic signed [Y_W-1:0]   Y_MAX = Y_W'(32767);
  localparam logic signed [Y_W-1:0]   Y_MIN = Y_W'(-32768);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] prod;
  logic signed [P_W-1:0]   p;
  logic signed [Y_W-1:0]   y;

  always_comb begin
    // 32x16 signed product fits exactly in ACC_W bits.
    prod  = ACC_W'(a_r) * ACC_W'(hist_k);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (mac_en) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  always_comb begin
    // Add half an LSB then arithmetic shift: round half toward +inf.
    p     = P_W'((acc_q + RND) >>> COEF_FRAC);
    y     = Y_W'(e) - Y_W'(p);
    y_ovf = 1'b0;
    y_sat = SAMP_W'(y);
    if (y > Y_MAX) begin
      y_sat = 16'sh7fff;
      y_ovf = 1'b1;
    end else if (y < Y_MIN) begin
      y_sat = 16'sh8000;
      y_ovf = 1'b1;
    end
  end

endmodule

// File: rtl/lpc_synthesis.sv
// lpc_synthesis: all-pole LPC synthesis filter for one 160-sample frame,
// x[n] = e[n] - round(sum_{k=1..10} a[k] * x[n-k]), 12 cycles per sample.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   start, ready   : frame start pulse (accepted only when idle), idle flag
//   residue_raddr  : residue memory address, residue_r: e[n] (comb read)
//   a_rsel         : one-hot coefficient select (bit k-1 -> a[k]), a_r: value
//   x_wen/x_waddr/x_w : output memory write port
//   sat            : sticky saturation flag for the current/last frame
// Build option: define LPC_SYNTH_CARRY_EN to keep the filter history across
// frames (only reset clears it); otherwise each accepted start clears it.
module lpc_synthesis
  import lpc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  output logic [7:0]        residue_raddr,
  input  logic [15:0]       residue_r,
  output logic [ORDER-1:0]  a_rsel,
  input  logic [31:0]       a_r,
  output logic              x_wen,
  output logic [7:0]        x_waddr,
  output logic [15:0]       x_w,
  output logic              sat
);

  synth_state_e state_q, state_d;
  logic [7:0]   n_q, n_d;
  logic [3:0]   k_q, k_d;
  sample_t      e_q, e_d;
  logic         sat_q, sat_d;
  sample_t      hist_q [ORDER];
  sample_t      hist_d [ORDER];

  sample_t      y_sat;
  logic         y_ovf;

  lpc_synth_mac u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_q == ST_LOAD),
    .mac_en (state_q == ST_MAC),
    .a_r    (coef_t'(a_r)),
    .hist_k (hist_q[k_q]),
    .e      (e_q),
    .y_sat  (y_sat),
    .y_ovf  (y_ovf)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    e_d     = e_q;
    sat_d   = sat_q;
    for (int i = 0; i < ORDER; i++) begin
      hist_d[i] = hist_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          n_d     = '0;
          sat_d   = 1'b0;
`ifndef LPC_SYNTH_CARRY_EN
          for (int i = 0; i < ORDER; i++) begin
            hist_d[i] = '0;
          end
`endif
        end
      end
      ST_LOAD: begin
        e_d     = sample_t'(residue_r);
        k_d     = '0;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        k_d = k_q + 4'd1;
        if (k_q == 4'(ORDER - 1)) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (y_ovf) begin
          sat_d = 1'b1;
        end
        // Newest sample enters at hist[0]; hist[k] holds x[n-1-k].
        hist_d[0] = y_sat;
        for (int i = 1; i < ORDER; i++) begin
          hist_d[i] = hist_q[i-1];
        end
        // A start seen here is dropped: the block must pass through IDLE.
        if (n_q == 8'(N_SAMPLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          n_d     = n_q + 8'd1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      k_q     <= '0;
      e_q     <= '0;
      sat_q   <= 1'b0;
      for (int i = 0; i < ORDER; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      e_q     <= e_d;
      sat_q   <= sat_d;
      for (int i = 0; i < ORDER; i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  // All outputs decode directly from flops, so reset forces them at once.
  assign ready         = (state_q == ST_IDLE);
  assign residue_raddr = n_q;
  assign a_rsel        = (state_q == ST_MAC) ? (ORDER'(1) << k_q) : '0;
  assign x_wen         = (state_q == ST_WRITE);
  assign x_waddr       = n_q;
  assign x_w           = y_sat;
  assign sat           = sat_q;

endmodule

// File: tb/tb_lpc_synthesis.sv
module tb_lpc_synthesis;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ready;
  logic [7:0]  residue_raddr;
  logic [15:0] residue_r;
  logic [9:0]  a_rsel;
  logic [31:0] a_r;
  logic        x_wen;
  logic [7:0]  x_waddr;
  logic [15:0] x_w;
  logic        sat;

  lpc_synthesis dut (
    .clk           (clk),
    .reset         (rst_n),
    .start         (start),
    .ready         (ready),
    .residue_raddr (residue_raddr),
    .residue_r     (residue_r),
    .a_rsel        (a_rsel),
    .a_r           (a_r),
    .x_wen         (x_wen),
    .x_waddr       (x_waddr),
    .x_w           (x_w),
    .sat           (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int rel;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          mon_rel;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          c0 = 0;
  int          writes_seen = 0;
  bit          exp_sat;
  longint      mh [10];
  logic [15:0] res_mem [256];
  logic [31:0] coef [10];
  int          x_mem [256];

  always @(posedge clk) cyc <= cyc + 1;

  // Combinational-read residue memory and one-hot coefficient mux.
  always_comb residue_r = res_mem[residue_raddr];
  always_comb begin
    a_r = '0;
    for (int k = 0; k < 10; k++) begin
      if (a_rsel[k]) a_r = coef[k];
    end
  end

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Output port monitor: pop the scoreboard on each write.
  always @(negedge clk) begin
    if (rst_n && x_wen) begin
      mon_rel = cyc - c0 + 1;
      writes_seen++;
      x_mem[x_waddr] = int'($signed(x_w));
      if (sb_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("x_waddr", x_waddr, mon_e.addr);
        check("x_w", $signed(x_w), mon_e.data);
        check("x_cycle", mon_rel, mon_e.rel);
        $display("wr n=%0d x=%0d cycle=%0d", x_waddr, $signed(x_w), mon_rel);
      end
    end
  end

  task automatic clear_model();
    for (int k = 0; k < 10; k++) mh[k] = 0;
  endtask

  // Reference filter: push one frame of expected writes.
  task automatic push_model();
    longint acc, p, y;
`ifndef LPC_SYNTH_CARRY_EN
    clear_model();
`endif
    exp_sat = 1'b0;
    for (int n = 0; n < 160; n++) begin
      acc = 0;
      for (int k = 0; k < 10; k++) acc += longint'($signed(coef[k])) * mh[k];
      p = (acc + (longint'(1) <<< 23)) >>> 24;
      y = longint'($signed(res_mem[n])) - p;
      if (y > 32767) begin y = 32767; exp_sat = 1'b1; end
      if (y < -32768) begin y = -32768; exp_sat = 1'b1; end
      sb_q.push_back('{n, int'(y), 12 + 12 * n});
      for (int k = 9; k > 0; k--) mh[k] = mh[k-1];
      mh[0] = y;
    end
  endtask

  task automatic set_data(input int mode);
    for (int i = 0; i < 256; i++) res_mem[i] = '0;
    for (int k = 0; k < 10; k++) coef[k] = '0;
    case (mode)
      0: for (int i = 0; i < 160; i++) res_mem[i] = 16'(i - 80);
      1: begin res_mem[0] = 16'd1000; coef[0] = 32'hFF800000; end
      2: begin res_mem[0] = 16'd30000; res_mem[1] = 16'd10000; coef[0] = 32'hFF000000; end
      3: begin for (int i = 0; i < 160; i++) res_mem[i] = 16'd1000; coef[0] = 32'hFF800000; end
      default: coef[0] = 32'hFF800000;
    endcase
  endtask

  task automatic run_frame(input bit hs, input int abort_rel);
    push_model();
    writes_seen = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; c0 = cyc;
    check("ready_after_start", ready, 0);
    for (int rel = 2; rel <= 1925; rel++) begin
      @(negedge clk);
      start = 1'b0;
      if (hs && (rel == 500 || rel == 1920)) start = 1'b1;
      if (rel == abort_rel) begin
        check("sat_before_abort", sat, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_x_wen", x_wen, 0);
        check("abort_ready", ready, 1);
        check("abort_sat", sat, 0);
        check("abort_a_rsel", a_rsel, 0);
        sb_q.delete();
        clear_model();
        @(negedge clk); rst_n = 1'b1;
        return;
      end
      if (rel == 1920) check("ready_1920", ready, 0);
      if (rel == 1921) check("ready_1921", ready, 1);
    end
    check("ready_idle_after", ready, 1);
    check("queue_empty", sb_q.size(), 0);
    check("write_count", writes_seen, 160);
    check("sat_end", sat, exp_sat);
  endtask

  initial begin
    int x159;
    longint cacc, cexp;
    set_data(0);
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_sat", sat, 0);
    check("rst_x_wen", x_wen, 0);
    check("rst_a_rsel", a_rsel, 0);
    check("rst_raddr", residue_raddr, 0);

    // Ramp, zero coefficients, with ignored mid-frame and end-of-frame starts.
    set_data(0);
    run_frame(1'b1, 0);

    // Saturating frame aborted by reset at cycle 300.
    set_data(2);
    run_frame(1'b0, 300);

    // Impulse through a[1] = -0.5 after the abort: history must be clear.
    set_data(1);
    run_frame(1'b0, 0);
    check("impulse_x0", x_mem[0], 1000);
    check("impulse_x1", x_mem[1], 500);
    check("impulse_x2", x_mem[2], 250);
    check("impulse_x3", x_mem[3], 125);
    check("impulse_x4", x_mem[4], 62);

    // Saturation with a[1] = -1.0; sat must hold after ready rises.
    set_data(2);
    run_frame(1'b0, 0);
    check("sat_x0", x_mem[0], 30000);
    check("sat_x1", x_mem[1], 32767);
    repeat (5) @(negedge clk);
    check("sat_held", sat, 1);

    // Back-to-back frames: history carry versus per-frame clear.
    set_data(3);
    run_frame(1'b0, 0);
    x159 = x_mem[159];
    set_data(4);
    run_frame(1'b0, 0);
    cacc = -(longint'(x159) <<< 23);
`ifdef LPC_SYNTH_CARRY_EN
    cexp = -((cacc + (longint'(1) <<< 23)) >>> 24);
`else
    cexp = 0;
`endif
    check("frame2_x0", x_mem[0], cexp);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lpc_synthesis.md
Name: lpc_synthesis

Overview:
Decoder-side all-pole synthesis filter. It is the stage directly downstream of the LPC encoder and consumes the residue memory plus the 10 predictor coefficients that the encoder produces. For one 160-sample frame it rebuilds x[n] = e[n] - round(sum_{k=1..10} a[k]*x[n-k]), which is the exact inverse of the encoder's inverse filter. It writes the reconstructed samples into a 16x160 output register, using the same memory-port style as the encoder's memories.

Parameters:
N_SAMPLES, 160, samples per frame; x/residue address range 0..N_SAMPLES-1
ORDER, 10, predictor order; width of one-hot a_rsel
COEF_FRAC, 24, fractional bits of the a coefficients (signed Q8.24)
ACC_W, 48, signed accumulator width

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins a frame when the block is idle
ready  out  1  high when idle or frame complete; low while a frame is processing
residue_raddr  out  8  residue memory read address (combinational-read memory)
residue_r  in  16  residue sample e[n], signed
a_rsel  out  ORDER  one-hot coefficient select; bit k-1 selects a[k]
a_r  in  32  selected coefficient, signed Q8.24
x_wen  out  1  output-memory write enable
x_waddr  out  8  output-memory write address
x_w  out  16  reconstructed sample, signed, saturated
sat  out  1  sticky flag: some sample saturated in the current frame

Behaviour:
- Reset (reset=0, asynchronous) has these effects:
  - state=IDLE, ready=1, sat=0, x_wen=0, a_rsel=0.
  - n=0, k=0, acc=0, e=0, history hist[0..ORDER-1]=0.
  - Reset asserted mid-frame aborts the frame immediately; no further writes occur.
- States are IDLE, LOAD, MAC, WRITE.
- IDLE:
  - ready=1.
  - start=1 at an edge moves to LOAD and sets ready=0, n=0, sat=0.
  - The same edge clears the history (see Optional Feature).
- LOAD:
  - residue_raddr=n; the edge captures e<=residue_r.
  - The edge also sets acc<=0 and k<=0, then moves to MAC.
- MAC (ORDER cycles):
  - a_rsel=1<<k; the edge performs acc<=acc+a_r*hist[k] (32x16 signed product, sign-extended to ACC_W).
  - The edge also performs k<=k+1.
  - When k=ORDER-1 the state moves to WRITE.
- WRITE:
  - p=(acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC, i.e. round half toward +inf with an arithmetic shift.
  - y=e-p is computed at full width, then saturated to [-32768, 32767].
  - x_wen=1, x_waddr=n, x_w=sat(y).
  - On saturation, sat<=1.
  - The edge shifts the history: hist[0]<=sat(y), hist[i]<=hist[i-1].
  - If n=N_SAMPLES-1 the next state is IDLE (ready=1). Otherwise n<=n+1 and the next state is LOAD.
- Outside their active states: x_wen=0, a_rsel=0, residue_raddr=n.
- Timing, with start sampled at edge 0:
  - Each sample takes 12 cycles.
  - Sample n is written in cycle 12+12n.
  - The last write is in cycle 1920; ready=1 from cycle 1921.
- start while busy (ready=0) is ignored. start in the same cycle the last WRITE completes is also ignored; the block returns to IDLE first.
- sat holds its value after the frame ends and is cleared only by the next accepted start or by reset.

Optional Feature:
LPC_SYNTH_CARRY_EN
- Defined: the history is not cleared at start, so filter memory carries across consecutive frames. Only reset clears it. This gives continuous decoding of a stream.
- Undefined: the history is cleared at every accepted start, so x[n<0]=0 per frame, matching the encoder's frame-local inverse filter.

Decomposition:
- Package lpc_pkg:
  - Constants N_SAMPLES=160, ORDER=10, COEF_FRAC=24, ACC_W=48.
  - Synthesis state enum (IDLE/LOAD/MAC/WRITE).
  - Sample and coefficient width typedefs (16/32).
- Sub-module lpc_synth_mac holds the accumulator, the multiply-add, and the round/subtract/saturate output path.
- The FSM, counters and history stay in lpc_synthesis.

Test Plan:
- All a=0, e[n]=n-80 -> x[n]=e[n] for all 160 samples; sat=0; exactly 160 x_wen pulses at cycles 12+12n.
- e[0]=1000, others 0, a[1]=0xFF800000 (-0.5), rest 0 -> x[0..4]=1000,500,250,125,62.
- e[0]=30000, e[1]=10000, others 0, a[1]=0xFF000000 (-1.0) -> x[0]=30000, x[1]=32767, sat=1 and held after ready rises.
- Handshake: ready=0 one cycle after start; a second start at cycle 500 is ignored (no restart, writes continue at n=41); ready=1 at cycle 1921.
- Assert reset at cycle 300 -> x_wen=0 immediately, ready=1, sat=0. A new start then begins again at n=0 with cleared history.
- With LPC_SYNTH_CARRY_EN defined: two back-to-back frames, frame 1 with a[1]=-0.5 and frame 2 with e all zero -> frame 2 x[0]=round(0.5*x_frame1[159]). Without the macro -> frame 2 is all zero.
